// File: rtl/host_switch_ctrl.sv
// rtl/host_switch_ctrl.sv - host select with heartbeat watchdogs and break-before-make bus handover
module host_switch_ctrl #(
  parameter int unsigned WDT_T     = 50000000,
  parameter int unsigned DEAD_T    = 16,
  parameter int unsigned HOLDOFF_T = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic force_swi,
  input  logic com_swi,
  input  logic heartbeat_a,
  input  logic heartbeat_b,
  input  logic power_on_a,
  input  logic power_on_b,
  input  logic reset_a_active,
  input  logic reset_b_active,
  output logic switch,
  output logic bus_en_a,
  output logic bus_en_b,
  output logic busy,
  output logic auto_swi,
  output logic reject,
  output logic wdt_exp_a,
  output logic wdt_exp_b
);

  typedef enum logic [1:0] {STABLE, BREAK, MAKE, HOLDOFF} state_t;

  state_t      state, state_n;
  logic [31:0] dead_cnt, hold_cnt;
  logic [31:0] cnt_a, cnt_b, cnt_a_n, cnt_b_n;
  logic [2:0]  sync_a, sync_b;
  logic        switch_n, bus_en_a_n, bus_en_b_n, busy_n, auto_n, reject_n;
  logic        req_switch, tgt_ok, host_exp, standby_ok, wdt_trig;

  // Two synchroniser flops plus one history flop per heartbeat; any edge is a sign of life.
  always_comb begin
    cnt_a_n = cnt_a;
    if (reset_a_active || !power_on_a || (sync_a[2] ^ sync_a[1])) cnt_a_n = '0;
    else if (cnt_a != WDT_T) cnt_a_n = cnt_a + 32'd1;
    cnt_b_n = cnt_b;
    if (reset_b_active || !power_on_b || (sync_b[2] ^ sync_b[1])) cnt_b_n = '0;
    else if (cnt_b != WDT_T) cnt_b_n = cnt_b + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a    <= '0;
      sync_b    <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      wdt_exp_a <= 1'b0;
      wdt_exp_b <= 1'b0;
    end else begin
      sync_a    <= {sync_a[1:0], heartbeat_a};
      sync_b    <= {sync_b[1:0], heartbeat_b};
      cnt_a     <= cnt_a_n;
      cnt_b     <= cnt_b_n;
      wdt_exp_a <= (cnt_a_n == WDT_T);
      wdt_exp_b <= (cnt_b_n == WDT_T);
    end
  end

  assign req_switch = force_swi && (com_swi != switch);
  assign tgt_ok     = com_swi ? (power_on_b && !reset_b_active) : (power_on_a && !reset_a_active);
  assign host_exp   = switch ? wdt_exp_b : wdt_exp_a;
  assign standby_ok = switch ? (power_on_a && !reset_a_active && !wdt_exp_a)
                             : (power_on_b && !reset_b_active && !wdt_exp_b);
  assign wdt_trig   = host_exp && standby_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STABLE;
      dead_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      dead_cnt <= (state == BREAK) ? dead_cnt + 32'd1 : '0;
      hold_cnt <= (state == HOLDOFF) ? hold_cnt + 32'd1 : '0;
    end
  end

  // A force request of any kind masks the watchdog for that cycle, so force wins ties.
  always_comb begin
    state_n = state;
    case (state)
      STABLE: begin
        if (force_swi) begin
          if (req_switch && tgt_ok) state_n = BREAK;
        end else if (wdt_trig) begin
          state_n = BREAK;
        end
      end
      BREAK:   if (dead_cnt == DEAD_T) state_n = MAKE;
      MAKE:    state_n = HOLDOFF;
      HOLDOFF: begin
        if (req_switch && tgt_ok) state_n = BREAK;
        else if (hold_cnt == HOLDOFF_T - 1) state_n = STABLE;
      end
      default: state_n = STABLE;
    endcase
  end

  always_comb begin
    switch_n   = switch;
    bus_en_a_n = !switch;
    bus_en_b_n = switch;
    busy_n     = 1'b1;
    auto_n     = 1'b0;
    reject_n   = 1'b0;
    case (state)
      STABLE: begin
        busy_n   = 1'b0;
        reject_n = req_switch && !tgt_ok;
        auto_n   = !force_swi && wdt_trig;
      end
      BREAK: begin
        bus_en_a_n = 1'b0;
        bus_en_b_n = 1'b0;
        reject_n   = force_swi;
      end
      MAKE: begin
        switch_n   = !switch;
        bus_en_a_n = switch;
        bus_en_b_n = !switch;
        reject_n   = force_swi;
      end
      HOLDOFF: begin
        busy_n   = (state_n != STABLE);
        reject_n = req_switch && !tgt_ok;
      end
      default: busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      switch   <= 1'b0;
      bus_en_a <= 1'b1;
      bus_en_b <= 1'b0;
      busy     <= 1'b0;
      auto_swi <= 1'b0;
      reject   <= 1'b0;
    end else begin
      switch   <= switch_n;
      bus_en_a <= bus_en_a_n;
      bus_en_b <= bus_en_b_n;
      busy     <= busy_n;
      auto_swi <= auto_n;
      reject   <= reject_n;
    end
  end

endmodule

// File: doc/host_switch_ctrl.md
Name: host_switch_ctrl

Overview:
- Downstream consumer of the UART command decoder.
- Turns decoded switch requests (force_swi pulse plus com_swi target) and per-CPU heartbeat watchdogs into the host-select signal `switch` and the two CPU bus enables.
- Switchovers are break-before-make with a guaranteed dead time, followed by a hold-off window that prevents oscillation.
- Its `switch` output drives the decoder's `switch` input (0 = CPU A host, 1 = CPU B host).

Parameters:
WDT_T, 50000000, heartbeat watchdog timeout in clk cycles (1 s at 50 MHz); 32-bit compare
DEAD_T, 16, cycles with both bus enables low during a switchover (>=1)
HOLDOFF_T, 1000, cycles after a switchover during which automatic switching is suppressed (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
force_swi  input  1  one-cycle request pulse from the command decoder
com_swi  input  1  requested host, sampled with force_swi (0 = A, 1 = B)
heartbeat_a  input  1  asynchronous toggle from CPU A; any edge means alive
heartbeat_b  input  1  asynchronous toggle from CPU B
power_on_a  input  1  CPU A power enable, 1 = powered
power_on_b  input  1  CPU B power enable
reset_a_active  input  1  CPU A held in reset
reset_b_active  input  1  CPU B held in reset
switch  output  1  current host, 0 = A, 1 = B
bus_en_a  output  1  CPU A owns the shared bus
bus_en_b  output  1  CPU B owns the shared bus
busy  output  1  switchover or hold-off in progress
auto_swi  output  1  one-cycle pulse when a watchdog-triggered switchover starts
reject  output  1  one-cycle pulse when a force request is refused
wdt_exp_a  output  1  CPU A watchdog expired (level)
wdt_exp_b  output  1  CPU B watchdog expired (level)

Behaviour:
- Reset, synchronous, highest priority:
  - Outputs: switch=0, bus_en_a=1, bus_en_b=0, busy=0, auto_swi=0, reject=0, wdt_exp_a=0, wdt_exp_b=0.
  - Internal: watchdog counters=0, synchronisers cleared, state=STABLE.
  - A reset asserted mid-switchover aborts it and returns to A as host.
- All outputs are registered.
- Heartbeat path:
  - Each heartbeat passes through a 2-flop synchroniser, then a third flop for edge detection.
  - A detected edge clears that CPU's 32-bit counter. Otherwise the counter increments and saturates at WDT_T.
  - wdt_exp_x = (cnt_x == WDT_T).
  - While reset_x_active=1 or power_on_x=0, cnt_x is held at 0 and wdt_exp_x=0.
- Standby healthy: power_on=1, reset_active=0 and wdt_exp=0 for the non-host CPU.
- State machine states: STABLE, BREAK, MAKE, HOLDOFF.
  - STABLE: the host's bus_en=1, the other's bus_en=0, busy=0.
    - force_swi=1 with com_swi==switch: no action, no pulse.
    - force_swi=1 with com_swi!=switch:
      - Target powered and not in reset: go to BREAK.
      - Otherwise: reject=1 for one cycle and stay in STABLE.
    - Else if the host's wdt_exp=1 and the standby is healthy: auto_swi=1 for one cycle, go to BREAK.
    - force_swi wins over a simultaneous watchdog trigger.
  - BREAK:
    - Both bus enables are 0, starting in the first cycle after the trigger cycle.
    - busy=1.
    - A dead counter counts DEAD_T cycles, then the block goes to MAKE.
  - MAKE (one cycle):
    - switch toggles.
    - The new host's bus_en=1, registered so it is visible on the next edge.
    - Hold-off counter cleared; go to HOLDOFF.
  - HOLDOFF:
    - busy=1 for HOLDOFF_T cycles, then STABLE.
    - Watchdog triggers are ignored.
    - A force_swi with a valid opposite target is accepted and goes to BREAK.
- Any force_swi during BREAK or MAKE gives reject=1 for one cycle; the request is dropped.
- Latency:
  - Trigger sampled at edge t.
  - Old bus_en falls at t+1.
  - New bus_en rises and switch changes at t+DEAD_T+2.
  - busy falls at t+DEAD_T+HOLDOFF_T+2.
- bus_en_a and bus_en_b are never 1 simultaneously in any cycle, including across reset.

Test Plan:
(All scenarios use DEAD_T=4, HOLDOFF_T=8, WDT_T=20; heartbeats toggle every 5 cycles unless stated.)
- Reset, then idle 50 cycles -> switch=0, bus_en_a=1, bus_en_b=0, busy=0, no auto_swi/reject pulses, wdt_exp both 0.
- force_swi pulse with com_swi=1 at edge t -> bus_en_a=0 at t+1; both enables 0 through t+5; switch=1 and bus_en_b=1 at t+6; busy=0 at t+14. Then force com_swi=1 again -> no change, no reject.
- Stop heartbeat_a while B is healthy and A is host -> wdt_exp_a=1 after 20 idle cycles, auto_swi pulse in the next cycle, switch=1 six cycles later. Repeat with power_on_b=0 -> no switch, wdt_exp_a stays 1.
- force_swi com_swi=1 with reset_b_active=1 -> reject pulse, switch stays 0. force_swi during BREAK -> reject pulse and the switchover completes unchanged.
- force_swi in the same cycle that the host watchdog expires -> exactly one switchover, no auto_swi pulse. Assert rst two cycles into BREAK -> next cycle switch=0, bus_en_a=1, busy=0.
- Scoreboard assertion over all scenarios: (bus_en_a & bus_en_b)==0 every cycle.
